// File: rtl/fuel_dispense_meter.sv
// Dispensed-volume and price meter owning the pump relay.
// Auto mode stops on a preset volume; manual mode pumps while held.
//
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   clear        : zero totals and return to IDLE
//   mode         : 0 = auto preset, 1 = manual (sampled in IDLE)
//   start, stop  : level controls; stop has priority
//   manual_req   : operator hold-to-pump request
//   target_vol   : preset volume, latched on leaving IDLE
//   unit_price   : price per volume unit, latched on leaving IDLE
//   relay_on     : registered pump relay drive
//   volume       : dispensed volume
//   price        : accumulated cost, saturating
//   done         : high in DONE
//   busy         : high in PUMP or HOLD
module fuel_dispense_meter #(
   parameter int TICK_CYCLES = 1704545,
   parameter int STEP        = 50,
   parameter int VOL_W       = 16,
   parameter int PRICE_W     = 32,
   parameter int UPRICE_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                mode,
   input  logic                start,
   input  logic                stop,
   input  logic                manual_req,
   input  logic [VOL_W-1:0]    target_vol,
   input  logic [UPRICE_W-1:0] unit_price,
   output logic                relay_on,
   output logic [VOL_W-1:0]    volume,
   output logic [PRICE_W-1:0]  price,
   output logic                done,
   output logic                busy
);

   localparam int CNT_W  = $clog2(TICK_CYCLES);
   localparam int PROD_W = VOL_W + UPRICE_W;
   localparam int SUM_W  =
      ((PRICE_W > PROD_W) ? PRICE_W : PROD_W) + 1;

   localparam logic [CNT_W-1:0] LP_LAST =
      CNT_W'(TICK_CYCLES - 1);
   localparam logic [VOL_W-1:0] LP_STEP = VOL_W'(STEP);
   localparam logic [VOL_W-1:0] LP_VMAX = {VOL_W{1'b1}};
   localparam logic [SUM_W-1:0] LP_PMAX =
      SUM_W'({PRICE_W{1'b1}});

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PUMP,
      ST_HOLD,
      ST_DONE
   } state_t;

   state_t                r_state;
   logic                  r_mode;
   logic [VOL_W-1:0]      r_target;
   logic [UPRICE_W-1:0]   r_uprice;
   logic [VOL_W-1:0]      r_vol;
   logic [PRICE_W-1:0]    r_price;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_relay;
   logic                  r_done;
   logic                  r_busy;

   logic                  w_tick;
   logic [VOL_W:0]        w_vsum;
   logic                  w_fin;
   logic [VOL_W-1:0]      w_d;
   logic [VOL_W-1:0]      w_vol_nxt;
   logic [PROD_W-1:0]     w_prod;
   logic [SUM_W-1:0]      w_psum;
   logic [PRICE_W-1:0]    w_price_nxt;

   assign w_tick = (r_state == ST_PUMP) && (r_cnt == LP_LAST);
   assign w_vsum = {1'b0, r_vol} + {1'b0, LP_STEP};

   // Step size for this interval; the last step is trimmed so the
   // volume lands exactly on the target (auto) or the ceiling (manual).
   always_comb begin
      w_fin = 1'b0;
      w_d   = LP_STEP;
      if (r_mode) begin
         if (w_vsum > {1'b0, LP_VMAX}) begin
            w_fin = 1'b1;
            w_d   = LP_VMAX - r_vol;
         end
      end else if (w_vsum >= {1'b0, r_target}) begin
         w_fin = 1'b1;
         w_d   = (r_target > r_vol) ? (r_target - r_vol) : '0;
      end
   end

   assign w_vol_nxt = r_vol + w_d;
   assign w_prod    = PROD_W'(w_d) * PROD_W'(r_uprice);

   // One spare bit above the wider operand catches any overflow.
   assign w_psum      = SUM_W'(r_price) + SUM_W'(w_prod);
   assign w_price_nxt = (w_psum > LP_PMAX) ?
                        {PRICE_W{1'b1}} : w_psum[PRICE_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_mode   <= 1'b0;
         r_target <= '0;
         r_uprice <= '0;
         r_vol    <= '0;
         r_price  <= '0;
         r_cnt    <= '0;
         r_relay  <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else if (clear) begin
         r_state  <= ST_IDLE;
         r_vol    <= '0;
         r_price  <= '0;
         r_cnt    <= '0;
         r_relay  <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               // Only the values present on the exit edge matter.
               r_mode   <= mode;
               r_target <= target_vol;
               r_uprice <= unit_price;
               r_cnt    <= '0;
               if (!stop && !mode && start) begin
                  if (target_vol == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_PUMP;
                     r_relay <= 1'b1;
                     r_busy  <= 1'b1;
                  end
               end else if (!stop && mode && manual_req) begin
                  r_state <= ST_PUMP;
                  r_relay <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_PUMP: begin
               // The interval in flight is counted even on a pause edge.
               r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
               if (w_tick) begin
                  r_vol   <= w_vol_nxt;
                  r_price <= w_price_nxt;
               end
               if (w_tick && w_fin) begin
                  r_state <= ST_DONE;
                  r_relay <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (stop || (r_mode && !manual_req)) begin
                  r_state <= ST_HOLD;
                  r_relay <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (!stop && (r_mode ? manual_req : start)) begin
                  r_state <= ST_PUMP;
                  r_relay <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_relay <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign relay_on = r_relay;
   assign volume   = r_vol;
   assign price    = r_price;
   assign done     = r_done;
   assign busy     = r_busy;

endmodule
